paddle_control: RTL and testbench
=================================

# paddle_control

Upstream stage of the Pong datapath. It generates the periodic `move` step strobe and the bounding boxes of the left and right paddles from four push-buttons. The paddle boxes stay inside the vertical playfield border. The ball-position stage consumes `move`, `LHmin..LVmax` and `RHmin..RVmax` directly on the same clock.

## Interface
Parameters:
- `TICK_DIV`, 400000: clock cycles per `move` strobe (250 Hz at 100 MHz); must be ≥2.
- `STEP`, 2: pixels a paddle moves per strobe.
- `PADDLE_H`, 60: paddle height; `LVmax` = `LVmin` + `PADDLE_H`.
- `PADDLE_W`, 10: paddle width.
- `LEFT_X`, 20: left paddle `LHmin`.
- `RIGHT_X`, 770: right paddle `RHmin`.
- `START_V`, 270: `LVmin`/`RVmin` after reset.

Ports:
- `CLK_100MHz`, in, 1: system clock.
- `Reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: high = game running; low = pause.
- `btnLUp`, `btnLDn`, `btnRUp`, `btnRDn`, in, 1 each: asynchronous raw buttons, active-high.
- `borderVmin`, `borderVmax`, in, 10: playfield vertical limits, quasi-static.
- `move`, out, 1: one-cycle step strobe.
- `LHmin`, `LHmax`, `LVmin`, `LVmax`, out, 10 each: left paddle box.
- `RHmin`, `RHmax`, `RVmin`, `RVmax`, out, 10 each: right paddle box.

## Operation
Synchronizers:
- Each button passes through a 2-flop synchronizer, reset to 0.
- Only the synchronized values are used.

Tick divider:
- `tick_cnt` is `ceil(log2(TICK_DIV))` bits wide and is cleared by reset.
- When `enable` = 1, it counts 0 to `TICK_DIV`-1 and wraps to 0.
- `move` is registered. It is 1 for exactly the cycle after `tick_cnt` = `TICK_DIV`-1 while enabled, and 0 otherwise.
- When `enable` = 0, `tick_cnt` holds its value and no `move` is issued.

Paddle registers:
- Only `LVmin` and `RVmin` are stored.
- `LVmax`/`RVmax` = `Vmin` + `PADDLE_H`.
- `LHmin`/`LHmax` = `LEFT_X` and `LEFT_X` + `PADDLE_W` (constants).
- `RHmin`/`RHmax` = `RIGHT_X` and `RIGHT_X` + `PADDLE_W` (constants).

Per-paddle FSM, evaluated only on the edge where `move` = 1 (a natural ~4 ms debounce). The direction decode is:
- IDLE: Up = Dn (neither or both pressed); `Vmin` is unchanged.
- UP: Up only. `Vmin` ← `Vmin` − `STEP` if `Vmin` ≥ `borderVmin` + `STEP`, else `borderVmin`.
- DOWN: Dn only. `Vmin` ← `Vmin` + `STEP` if `Vmin` + `PADDLE_H` + `STEP` ≤ `borderVmax`, else `borderVmax` − `PADDLE_H`.

Arithmetic:
- All comparisons are done in 11 bits, so there is no 10-bit wrap-around.
- A paddle never leaves [`borderVmin`, `borderVmax`] once inside it.

Paddle independence:
- The left and right paddles update independently in the same `move` cycle.
- Simultaneous presses on both paddles are legal.

## Timing
Reset values:
- `move` = 0, `tick_cnt` = 0, synchronizers = 0.
- `LVmin` = `RVmin` = `START_V` (`LVmax` = `RVmax` = 330 by default).
- `LHmin` = 20, `LHmax` = 30, `RHmin` = 770, `RHmax` = 780.
- All outputs are valid in the first cycle after `Reset` deasserts.

Strobe timing:
- First `move` occurs `TICK_DIV` + 1 cycles after reset release with `enable` = 1.
- Thereafter the period is exactly `TICK_DIV` cycles.

Update latency:
- Paddle values change on the edge at which `move` = 1, and are visible the following cycle.
- The ball stage samples the old paddle values on that same edge.

Button latency:
- A button must be high for ≥3 cycles before the `move` edge to be seen.
- Worst-case press-to-motion is 2 + `TICK_DIV` cycles.

Pause:
- Deasserting `enable` mid-period freezes `tick_cnt`.
- On re-enable, the remaining count resumes; the period is not restarted.

Reset mid-operation:
- All state returns to reset values on the next edge.
- Any pending `move` is cancelled.

## Test plan
- Free-run, `TICK_DIV` = 4, `enable` = 1, no buttons → `move` = 1 at cycles 5, 9, 13, … after reset; all paddle outputs constant at reset values.
- `btnLUp` held, `STEP` = 2, `borderVmin` = 5 → `LVmin` 270→268→… →6→5, then holds at 5; `LVmax` tracks `LVmin` + 60; right paddle unchanged.
- `btnRDn` held, `borderVmax` = 595 → `RVmin` increments by 2 and stops at 535 (`RVmax` = 595) with no overshoot or wrap.
- Both `btnLUp` and `btnLDn` held, while `btnRUp` pulses 1 cycle between strobes → `LVmin` stays 270; `RVmin` stays 270 (pulse not sampled at a `move` edge).
- `enable` dropped for 10 cycles when `tick_cnt` = 2, `TICK_DIV` = 4 → no `move` during pause; next `move` one cycle after re-enable plus remaining count (cnt 3), period resumes at 4.
- `Reset` asserted while `LVmin` = 100 and `tick_cnt` = 3 → next cycle `LVmin` = 270, `move` = 0, first strobe `TICK_DIV` + 1 cycles after release.

Source files
------------

// File: rtl/paddle_control.sv
// Pong paddle stage: button synchronizers, periodic move strobe, and the
// left/right paddle bounding boxes clamped to the vertical playfield border.
module paddle_control #(
  parameter int TICK_DIV = 400000,
  parameter int STEP     = 2,
  parameter int PADDLE_H = 60,
  parameter int PADDLE_W = 10,
  parameter int LEFT_X   = 20,
  parameter int RIGHT_X  = 770,
  parameter int START_V  = 270
) (
  input  logic       CLK_100MHz,
  input  logic       Reset,
  input  logic       enable,
  input  logic       btnLUp,
  input  logic       btnLDn,
  input  logic       btnRUp,
  input  logic       btnRDn,
  input  logic [9:0] borderVmin,
  input  logic [9:0] borderVmax,
  output logic       move,
  output logic [9:0] LHmin,
  output logic [9:0] LHmax,
  output logic [9:0] LVmin,
  output logic [9:0] LVmax,
  output logic [9:0] RHmin,
  output logic [9:0] RHmax,
  output logic [9:0] RVmin,
  output logic [9:0] RVmax
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, UP, DOWN} dir_t;

  logic [3:0]       btn_meta;
  logic [3:0]       btn_sync;
  logic [CNT_W-1:0] tick_cnt;
  logic [9:0]       l_vmin;
  logic [9:0]       r_vmin;

  // Bit order: {LUp, LDn, RUp, RDn}
  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= {btnLUp, btnLDn, btnRUp, btnRDn};
      btn_sync <= btn_meta;
    end
  end

  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      tick_cnt <= '0;
      move     <= 1'b0;
    end else if (enable) begin
      if (tick_cnt == CNT_LAST) begin
        tick_cnt <= '0;
        move     <= 1'b1;
      end else begin
        tick_cnt <= tick_cnt + CNT_W'(1);
        move     <= 1'b0;
      end
    end else begin
      move <= 1'b0;
    end
  end

  function automatic dir_t decode(input logic up, input logic dn);
    if (up && !dn)      decode = UP;
    else if (dn && !up) decode = DOWN;
    else                decode = IDLE;
  endfunction

  // Border checks use 11 bits so v+H+STEP can never wrap past 1023.
  function automatic logic [9:0] next_v(input dir_t dir, input logic [9:0] v,
                                        input logic [9:0] bmin, input logic [9:0] bmax);
    logic [10:0] v11;
    logic [10:0] lo11;
    logic [10:0] hi11;
    v11    = {1'b0, v};
    lo11   = {1'b0, bmin};
    hi11   = {1'b0, bmax};
    next_v = v;
    case (dir)
      UP:
        if (v11 >= lo11 + 11'(STEP)) next_v = v - 10'(STEP);
        else                         next_v = bmin;
      DOWN:
        if (v11 + 11'(PADDLE_H) + 11'(STEP) <= hi11) next_v = v + 10'(STEP);
        else                                         next_v = bmax - 10'(PADDLE_H);
      default: next_v = v;
    endcase
  endfunction

  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      l_vmin <= 10'(START_V);
      r_vmin <= 10'(START_V);
    end else if (move) begin
      l_vmin <= next_v(decode(btn_sync[3], btn_sync[2]), l_vmin, borderVmin, borderVmax);
      r_vmin <= next_v(decode(btn_sync[1], btn_sync[0]), r_vmin, borderVmin, borderVmax);
    end
  end

  assign LHmin = 10'(LEFT_X);
  assign LHmax = 10'(LEFT_X + PADDLE_W);
  assign RHmin = 10'(RIGHT_X);
  assign RHmax = 10'(RIGHT_X + PADDLE_W);
  assign LVmin = l_vmin;
  assign LVmax = l_vmin + 10'(PADDLE_H);
  assign RVmin = r_vmin;
  assign RVmax = r_vmin + 10'(PADDLE_H);

endmodule

// File: tb/tb_paddle_control.sv
// Randomized self-checking bench for paddle_control against a cycle-level
// behavioural model built from the strobe and paddle-motion rules.
module tb_paddle_control;

  localparam int TICK    = 4;
  localparam int STEP    = 2;
  localparam int PH      = 60;
  localparam int START_V = 270;

  logic       CLK_100MHz = 1'b0;
  logic       Reset = 1'b1;
  logic       enable = 1'b0;
  logic       btnLUp = 1'b0, btnLDn = 1'b0, btnRUp = 1'b0, btnRDn = 1'b0;
  logic [9:0] borderVmin = 10'd5;
  logic [9:0] borderVmax = 10'd595;
  logic       move;
  logic [9:0] LHmin, LHmax, LVmin, LVmax, RHmin, RHmax, RVmin, RVmax;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  int       m_en;
  bit       m_mv;
  int       m_lv, m_rv;
  bit [3:0] h1, h2;

  paddle_control #(
    .TICK_DIV(TICK), .STEP(STEP), .PADDLE_H(PH), .PADDLE_W(10),
    .LEFT_X(20), .RIGHT_X(770), .START_V(START_V)
  ) dut (
    .CLK_100MHz(CLK_100MHz), .Reset(Reset), .enable(enable),
    .btnLUp(btnLUp), .btnLDn(btnLDn), .btnRUp(btnRUp), .btnRDn(btnRDn),
    .borderVmin(borderVmin), .borderVmax(borderVmax), .move(move),
    .LHmin(LHmin), .LHmax(LHmax), .LVmin(LVmin), .LVmax(LVmax),
    .RHmin(RHmin), .RHmax(RHmax), .RVmin(RVmin), .RVmax(RVmax)
  );

  always #5 CLK_100MHz = ~CLK_100MHz;

  function automatic int paddle_ref(input int v, input bit up, input bit dn);
    int nv;
    nv = v;
    if (up && !dn) begin
      nv = v - STEP;
      if (nv < int'(borderVmin)) nv = int'(borderVmin);
    end else if (dn && !up) begin
      nv = v + STEP;
      if (nv + PH > int'(borderVmax)) nv = int'(borderVmax) - PH;
    end
    return nv;
  endfunction

  // Advance one clock and the model; inputs sampled as they stand at the edge.
  task automatic step();
    @(posedge CLK_100MHz);
    if (Reset) begin
      m_en = 0; m_mv = 0; m_lv = START_V; m_rv = START_V; h1 = '0; h2 = '0;
    end else begin
      if (m_mv) begin
        m_lv = paddle_ref(m_lv, h2[3], h2[2]);
        m_rv = paddle_ref(m_rv, h2[1], h2[0]);
      end
      h2 = h1;
      h1 = {btnLUp, btnLDn, btnRUp, btnRDn};
      if (enable) begin
        m_en++;
        m_mv = (m_en % TICK) == 0;
      end else begin
        m_mv = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    {btnLUp, btnLDn, btnRUp, btnRDn} = '0;
    enable = 1'b0;
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (move !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_move: got %0b want 0", move); end
    compared++;
    if ({LHmin, LHmax, RHmin, RHmax} !== {10'd20, 10'd30, 10'd770, 10'd780}) begin
      mismatched++;
      $display("[TB] FAIL reset_hbox: got %0d %0d %0d %0d want 20 30 770 780", LHmin, LHmax, RHmin, RHmax);
    end
    compared++;
    if ({LVmin, LVmax, RVmin, RVmax} !== {10'd270, 10'd330, 10'd270, 10'd330}) begin
      mismatched++;
      $display("[TB] FAIL reset_vbox: got %0d %0d %0d %0d want 270 330 270 330", LVmin, LVmax, RVmin, RVmax);
    end
  endtask

  task automatic test_free_run();
    do_reset();
    enable = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      step();
      compared++;
      if (move !== ((k % TICK) == 0)) begin
        mismatched++;
        $display("[TB] FAIL free_run_move: step %0d got %0b want %0b", k, move, (k % TICK) == 0);
      end
      compared++;
      if (LVmin !== 10'd270 || RVmin !== 10'd270) begin
        mismatched++;
        $display("[TB] FAIL free_run_vmin: got %0d/%0d want 270/270", LVmin, RVmin);
      end
    end
  endtask

  task automatic test_left_up();
    do_reset();
    borderVmin = 10'd5;
    btnLUp = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 600; k++) begin
      step();
      compared++;
      if (LVmin !== 10'(m_lv) || LVmax !== 10'(m_lv + PH) || RVmin !== 10'd270) begin
        mismatched++;
        $display("[TB] FAIL left_up: got L %0d/%0d R %0d want L %0d/%0d R 270",
                 LVmin, LVmax, RVmin, m_lv, m_lv + PH);
      end
    end
    compared++;
    if (LVmin !== 10'd5) begin mismatched++; $display("[TB] FAIL left_up_floor: got %0d want 5", LVmin); end
  endtask

  task automatic test_right_down();
    do_reset();
    borderVmax = 10'd595;
    btnRDn = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 600; k++) begin
      step();
      compared++;
      if (RVmin !== 10'(m_rv) || RVmax !== 10'(m_rv + PH) || LVmin !== 10'd270) begin
        mismatched++;
        $display("[TB] FAIL right_down: got R %0d/%0d L %0d want R %0d/%0d L 270",
                 RVmin, RVmax, LVmin, m_rv, m_rv + PH);
      end
    end
    compared++;
    if (RVmin !== 10'd535 || RVmax !== 10'd595) begin
      mismatched++;
      $display("[TB] FAIL right_down_ceiling: got %0d/%0d want 535/595", RVmin, RVmax);
    end
  endtask

  // One-cycle btnRUp pulses placed so the synchronized copy misses every move edge.
  task automatic test_both_and_pulse();
    do_reset();
    btnLUp = 1'b1;
    btnLDn = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 200; k++) begin
      btnRUp = ((m_en % TICK) == 0) && ($urandom_range(0, 1) == 1);
      step();
      compared++;
      if (LVmin !== 10'd270 || RVmin !== 10'd270 || RVmin !== 10'(m_rv)) begin
        mismatched++;
        $display("[TB] FAIL both_pulse: got L %0d R %0d want L 270 R 270", LVmin, RVmin);
      end
    end
    btnRUp = 1'b0;
  endtask

  task automatic test_pause();
    int guard;
    do_reset();
    enable = 1'b1;
    guard = 0;
    while ((m_en % TICK) != 2 && guard < 10) begin step(); guard++; end
    compared++;
    if ((m_en % TICK) != 2) begin mismatched++; $display("[TB] FAIL pause_setup: got phase %0d want 2", m_en % TICK); end
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      compared++;
      if (move !== 1'b0) begin mismatched++; $display("[TB] FAIL pause_move: got %0b want 0", move); end
    end
    enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      compared++;
      if (move !== ((k % TICK) == 2)) begin
        mismatched++;
        $display("[TB] FAIL pause_resume: step %0d got %0b want %0b", k, move, (k % TICK) == 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    do_reset();
    borderVmin = 10'd5;
    enable = 1'b1;
    btnLUp = 1'b1;
    guard = 0;
    while (m_lv > 100 && guard < 1000) begin step(); guard++; end
    btnLUp = 1'b0;
    guard = 0;
    while ((m_en % TICK) != 3 && guard < 10) begin step(); guard++; end
    compared++;
    if (LVmin !== 10'(m_lv) || m_lv > 100) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_setup: got %0d want %0d (<=100)", LVmin, m_lv);
    end
    Reset = 1'b1;
    step();
    compared++;
    if (LVmin !== 10'd270 || move !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_state: got LVmin %0d move %0b want 270 0", LVmin, move);
    end
    Reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      compared++;
      if (move !== ((k % TICK) == 0)) begin
        mismatched++;
        $display("[TB] FAIL reset_mid_strobe: step %0d got %0b want %0b", k, move, (k % TICK) == 0);
      end
    end
  endtask

  // Random held button combinations on both paddles, random pauses and borders.
  task automatic test_random();
    int hold;
    do_reset();
    borderVmin = 10'($urandom_range(0, 100));
    borderVmax = 10'($urandom_range(500, 700));
    hold = 0;
    for (int k = 0; k < 3000; k++) begin
      if (hold == 0) begin
        {btnLUp, btnLDn, btnRUp, btnRDn} = 4'($urandom);
        enable = ($urandom_range(0, 9) != 0);
        hold = $urandom_range(1, 40);
      end
      hold--;
      step();
      compared++;
      if (move !== m_mv || LVmin !== 10'(m_lv) || RVmin !== 10'(m_rv) ||
          LVmax !== 10'(m_lv + PH) || RVmax !== 10'(m_rv + PH)) begin
        mismatched++;
        $display("[TB] FAIL random: step %0d got mv %0b L %0d/%0d R %0d/%0d want mv %0b L %0d/%0d R %0d/%0d",
                 k, move, LVmin, LVmax, RVmin, RVmax, m_mv, m_lv, m_lv + PH, m_rv, m_rv + PH);
      end
    end
    compared++;
    if ({LHmin, LHmax, RHmin, RHmax} !== {10'd20, 10'd30, 10'd770, 10'd780}) begin
      mismatched++;
      $display("[TB] FAIL random_hbox: got %0d %0d %0d %0d want 20 30 770 780", LHmin, LHmax, RHmin, RHmax);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_left_up();
    test_right_down();
    test_both_and_pulse();
    test_pause();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
